// File: rtl/seg7_scan_controller.sv
// Bus-mapped 4-digit 7-segment scan controller: write-only register file, per-slot
// PWM brightness, inter-digit blanking guard and frame-based blink.
module seg7_scan_controller #(
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         DIGIT_TICKS = 100000,
  parameter int         BLANK_TICKS = 1000,
  parameter int         BLINK_SCANS = 125
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [3:0] DISP_SEL_OUT,
  output logic [7:0] DISP_OUT,
  output logic       FRAME_TICK
);

  // state    | meaning
  // ST_IDLE  | display disabled, all pins off, index/counter parked at 0
  // ST_ON    | digit slot, lit for the first on_len counts
  // ST_GUARD | all-off blanking after each slot, advances the digit index
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GUARD} state_t;

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int BW        = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] ON_STEP    = CW'(DIGIT_TICKS / 8);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  localparam logic [7:0] ADDR_D01  = BASE_ADDR;
  localparam logic [7:0] ADDR_D23  = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_MASK = BASE_ADDR + 8'd2;
  localparam logic [7:0] ADDR_CTRL = BASE_ADDR + 8'd3;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: hexseg = 7'h40;  4'h1: hexseg = 7'h79;
      4'h2: hexseg = 7'h24;  4'h3: hexseg = 7'h30;
      4'h4: hexseg = 7'h19;  4'h5: hexseg = 7'h12;
      4'h6: hexseg = 7'h02;  4'h7: hexseg = 7'h78;
      4'h8: hexseg = 7'h00;  4'h9: hexseg = 7'h10;
      4'hA: hexseg = 7'h08;  4'hB: hexseg = 7'h03;
      4'hC: hexseg = 7'h46;  4'hD: hexseg = 7'h21;
      4'hE: hexseg = 7'h06;  default: hexseg = 7'h0E;
    endcase
  endfunction

  logic [15:0] digits_q;
  logic [3:0]  dot_q;
  logic [3:0]  en_q;
  logic [2:0]  bright_q;
  logic        disp_en_q;
  logic        blink_en_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      digits_q   <= '0;
      dot_q      <= '0;
      en_q       <= 4'hF;
      bright_q   <= 3'd7;
      disp_en_q  <= 1'b1;
      blink_en_q <= 1'b0;
    end else if (BUS_WE) begin
      if (BUS_ADDR == ADDR_D01) begin
        digits_q[7:0] <= BUS_DATA;
      end else if (BUS_ADDR == ADDR_D23) begin
        digits_q[15:8] <= BUS_DATA;
      end else if (BUS_ADDR == ADDR_MASK) begin
        dot_q <= BUS_DATA[3:0];
        en_q  <= BUS_DATA[7:4];
      end else if (BUS_ADDR == ADDR_CTRL) begin
        bright_q   <= BUS_DATA[2:0];
        disp_en_q  <= BUS_DATA[3];
        blink_en_q <= BUS_DATA[4];
      end
    end
  end

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bright_l_q, bright_l_d;
  logic [3:0]      nib_l_q, nib_l_d;
  logic            dot_l_q, dot_l_d;
  logic            en_l_q, en_l_d;
  logic [3:0]      sel_q, sel_d;
  logic [7:0]      seg_q, seg_d;
  logic            tick_q, tick_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_ph_q, blink_ph_d;
  logic [CW-1:0]   on_len;
  logic            lit;
  logic            load;
  logic            frame_end;

  assign on_len = CW'(bright_l_q) * ON_STEP + ON_STEP;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    bright_l_d  = bright_l_q;
    nib_l_d     = nib_l_q;
    dot_l_d     = dot_l_q;
    en_l_d      = en_l_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    load        = 1'b0;
    frame_end   = 1'b0;

    lit   = (state_q == ST_ON) && (cnt_q < on_len) && en_l_q && !(blink_en_q && blink_ph_q);
    sel_d = lit ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d = lit ? {~dot_l_q, hexseg(nib_l_q)} : 8'hFF;

    if (!disp_en_q) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ON;
          idx_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
        ST_ON: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GUARD: begin
          if (cnt_q == BLANK_LAST) begin
            state_d   = ST_ON;
            cnt_d     = '0;
            idx_d     = idx_q + 2'd1;
            load      = 1'b1;
            frame_end = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Slot snapshot: mid-slot register writes only show up from the next slot.
    if (load) begin
      bright_l_d = bright_q;
      nib_l_d    = digits_q[{idx_d, 2'b00} +: 4];
      dot_l_d    = dot_q[idx_d];
      en_l_d     = en_q[idx_d];
    end

    tick_d = frame_end;

    if (!blink_en_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_ON;
      idx_q       <= '0;
      cnt_q       <= '0;
      bright_l_q  <= 3'd7;
      nib_l_q     <= '0;
      dot_l_q     <= 1'b0;
      en_l_q      <= 1'b1;
      sel_q       <= 4'hF;
      seg_q       <= 8'hFF;
      tick_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      bright_l_q  <= bright_l_d;
      nib_l_q     <= nib_l_d;
      dot_l_q     <= dot_l_d;
      en_l_q      <= en_l_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign DISP_SEL_OUT = sel_q;
  assign DISP_OUT     = seg_q;
  assign FRAME_TICK   = tick_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller with a 72-cycle frame (16-tick slots, 2-tick guard).
module tb_seg7_scan_controller;

  localparam logic [7:0] BASE = 8'hD0;
  localparam int FRAME = 72;
  localparam int SLOT  = 18;
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] BUS_DATA = '0;
  logic [7:0] BUS_ADDR = '0;
  logic       BUS_WE = 1'b0;
  logic [3:0] DISP_SEL_OUT;
  logic [7:0] DISP_OUT;
  logic       FRAME_TICK;

  seg7_scan_controller #(
    .BASE_ADDR(BASE), .DIGIT_TICKS(16), .BLANK_TICKS(2), .BLINK_SCANS(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
    .DISP_SEL_OUT(DISP_SEL_OUT), .DISP_OUT(DISP_OUT), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] out;
    int         lit;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] obs_sel [4];
  logic [7:0] obs_out [4];
  int         obs_lit [4];
  logic       obs_shape [4];
  int         obs_ticks;
  int         obs_tick_pos;

  function automatic logic [7:0] seg_exp(input logic [3:0] n, input logic dp);
    logic [7:0] v;
    v = HEX[n];
    return {~dp, v[6:0]};
  endfunction

  task automatic push_slot(input int d, input logic [7:0] out, input int lit);
    exp_t e;
    e.sel = (lit > 0) ? (4'hF ^ (4'h1 << d)) : 4'hF;
    e.out = (lit > 0) ? out : 8'hFF;
    e.lit = lit;
    sb.push_back(e);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    BUS_WE = 1'b1; BUS_ADDR = a; BUS_DATA = d;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (FRAME_TICK === 1'b1) break;
    end
    if (k == 200) begin
      n_tests++; n_fail++;
      $display("FAIL %s wait_tick: no FRAME_TICK in 200 cycles, required one", name);
    end
  endtask

  // Observes one frame starting on the sample after a tick; optional one-cycle write at sample wr_at.
  task automatic capture_frame(input int wr_at, input logic [7:0] wa, input logic [7:0] wd);
    int s, c;
    for (int i = 0; i < 4; i++) begin
      obs_sel[i] = 4'hF; obs_out[i] = 8'hFF; obs_lit[i] = 0; obs_shape[i] = 1'b1;
    end
    obs_ticks = 0; obs_tick_pos = -1;
    for (int g = 0; g < FRAME; g++) begin
      @(negedge CLK);
      s = g / SLOT; c = g % SLOT;
      if (DISP_SEL_OUT !== 4'hF) begin
        if (c != obs_lit[s]) obs_shape[s] = 1'b0;
        if (obs_lit[s] == 0) begin
          obs_sel[s] = DISP_SEL_OUT; obs_out[s] = DISP_OUT;
        end else if (DISP_SEL_OUT !== obs_sel[s] || DISP_OUT !== obs_out[s]) begin
          obs_shape[s] = 1'b0;
        end
        obs_lit[s]++;
      end else if (DISP_OUT !== 8'hFF) begin
        obs_shape[s] = 1'b0;
      end
      if (FRAME_TICK === 1'b1) begin obs_ticks++; obs_tick_pos = g; end
      BUS_WE = (g == wr_at); BUS_ADDR = wa; BUS_DATA = wd;
    end
    BUS_WE = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    repeat (3) @(negedge CLK);
    n_tests++;
    if (DISP_SEL_OUT !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %h want f", DISP_SEL_OUT); end
    n_tests++;
    if (DISP_OUT !== 8'hFF) begin n_fail++; $display("FAIL reset_out: got %h want ff", DISP_OUT); end
    n_tests++;
    if (FRAME_TICK !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", FRAME_TICK); end
    RESET = 1'b0;
    for (int d = 0; d < 4; d++) push_slot(d, seg_exp(4'h0, 1'b0), 16);
    capture_frame(-1, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front(); n_tests++;
      if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                 s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
      end
    end
    n_tests++;
    if (obs_ticks != 1 || obs_tick_pos != FRAME - 1) begin
      n_fail++; $display("FAIL reset_frame_tick: got count=%0d pos=%0d want count=1 pos=71", obs_ticks, obs_tick_pos);
    end
  endtask

  task automatic test_digits;
    exp_t e;
    bus_write(BASE, 8'h21);
    bus_write(BASE + 8'd1, 8'h43);
    wait_tick("digits");
    push_slot(0, seg_exp(4'h1, 1'b0), 16);
    push_slot(1, seg_exp(4'h2, 1'b0), 16);
    push_slot(2, seg_exp(4'h3, 1'b0), 16);
    push_slot(3, seg_exp(4'h4, 1'b0), 16);
    capture_frame(-1, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front(); n_tests++;
      if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL digits_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                 s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
      end
    end
    n_tests++;
    if (obs_ticks != 1 || obs_tick_pos != FRAME - 1) begin
      n_fail++; $display("FAIL digits_frame_tick: got count=%0d pos=%0d want count=1 pos=71", obs_ticks, obs_tick_pos);
    end
  endtask

  // Bright 3 with display enabled; written mid-slot-0 so slot 0 keeps its full-on snapshot.
  task automatic test_bright;
    exp_t e;
    wait_tick("bright");
    push_slot(0, seg_exp(4'h1, 1'b0), 16);
    push_slot(1, seg_exp(4'h2, 1'b0), 8);
    push_slot(2, seg_exp(4'h3, 1'b0), 8);
    push_slot(3, seg_exp(4'h4, 1'b0), 8);
    capture_frame(5, BASE + 8'd3, 8'h0B);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front(); n_tests++;
      if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL bright_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                 s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
      end
    end
    n_tests++;
    if (obs_ticks != 1 || obs_tick_pos != FRAME - 1) begin
      n_fail++; $display("FAIL bright_frame_tick: got count=%0d pos=%0d want count=1 pos=71", obs_ticks, obs_tick_pos);
    end
  endtask

  task automatic test_mask;
    exp_t e;
    bus_write(BASE + 8'd2, 8'h51);
    wait_tick("mask");
    push_slot(0, seg_exp(4'h1, 1'b1), 8);
    push_slot(1, 8'hFF, 0);
    push_slot(2, seg_exp(4'h3, 1'b0), 8);
    push_slot(3, 8'hFF, 0);
    capture_frame(-1, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front(); n_tests++;
      if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL mask_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                 s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
      end
    end
    n_tests++;
    if (obs_ticks != 1 || obs_tick_pos != FRAME - 1) begin
      n_fail++; $display("FAIL mask_frame_tick: got count=%0d pos=%0d want count=1 pos=71", obs_ticks, obs_tick_pos);
    end
  endtask

  task automatic test_blink;
    exp_t e;
    int   pattern [4] = '{16, 0, 0, 16};
    bus_write(BASE + 8'd2, 8'hF0);
    bus_write(BASE + 8'd3, 8'h1F);
    wait_tick("blink");
    for (int f = 0; f < 4; f++) begin
      push_slot(0, seg_exp(4'h1, 1'b0), pattern[f]);
      push_slot(1, seg_exp(4'h2, 1'b0), pattern[f]);
      push_slot(2, seg_exp(4'h3, 1'b0), pattern[f]);
      push_slot(3, seg_exp(4'h4, 1'b0), pattern[f]);
      capture_frame(-1, 8'h00, 8'h00);
      for (int s = 0; s < 4; s++) begin
        e = sb.pop_front(); n_tests++;
        if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
          n_fail++;
          $display("FAIL blink_f%0d_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                   f, s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
        end
      end
      n_tests++;
      if (obs_ticks != 1 || obs_tick_pos != FRAME - 1) begin
        n_fail++; $display("FAIL blink_f%0d_frame_tick: got count=%0d pos=%0d want count=1 pos=71", f, obs_ticks, obs_tick_pos);
      end
    end
  endtask

  task automatic test_idle;
    exp_t e;
    int   lit_cnt, tick_cnt;
    bus_write(BASE + 8'd3, 8'h0F);
    wait_tick("idle");
    repeat (40) @(negedge CLK);
    n_tests++;
    if (DISP_SEL_OUT !== 4'b1011 || DISP_OUT !== HEX[3]) begin
      n_fail++; $display("FAIL idle_pre: got %h/%h want b/%h", DISP_SEL_OUT, DISP_OUT, HEX[3]);
    end
    BUS_WE = 1'b1; BUS_ADDR = BASE + 8'd3; BUS_DATA = 8'h07;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      BUS_WE = 1'b0;
      n_tests++;
      if (k < 3 && (DISP_SEL_OUT !== 4'b1011 || DISP_OUT !== HEX[3])) begin
        n_fail++; $display("FAIL idle_lag%0d: got %h/%h want b/%h", k, DISP_SEL_OUT, DISP_OUT, HEX[3]);
      end else if (k == 3 && (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF)) begin
        n_fail++; $display("FAIL idle_off: got %h/%h want f/ff", DISP_SEL_OUT, DISP_OUT);
      end
    end
    lit_cnt = 0; tick_cnt = 0;
    repeat (100) begin
      @(negedge CLK);
      if (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF) lit_cnt++;
      if (FRAME_TICK !== 1'b0) tick_cnt++;
    end
    n_tests++;
    if (lit_cnt != 0 || tick_cnt != 0) begin
      n_fail++; $display("FAIL idle_hold: got lit=%0d ticks=%0d want 0/0", lit_cnt, tick_cnt);
    end
    BUS_WE = 1'b1; BUS_ADDR = BASE + 8'd3; BUS_DATA = 8'h0F;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      BUS_WE = 1'b0;
      n_tests++;
      if (k < 3 && (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF)) begin
        n_fail++; $display("FAIL resume_lag%0d: got %h/%h want f/ff", k, DISP_SEL_OUT, DISP_OUT);
      end else if (k == 3 && (DISP_SEL_OUT !== 4'b1110 || DISP_OUT !== HEX[1])) begin
        n_fail++; $display("FAIL resume_on: got %h/%h want e/%h", DISP_SEL_OUT, DISP_OUT, HEX[1]);
      end
    end
    wait_tick("resume");
    push_slot(0, seg_exp(4'h1, 1'b0), 16);
    push_slot(1, seg_exp(4'h2, 1'b0), 16);
    push_slot(2, seg_exp(4'h3, 1'b0), 16);
    push_slot(3, seg_exp(4'h4, 1'b0), 16);
    capture_frame(-1, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front(); n_tests++;
      if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL resume_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                 s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    wait_tick("reset_mid");
    repeat (20) @(negedge CLK);
    n_tests++;
    if (DISP_SEL_OUT !== 4'b1101 || DISP_OUT !== HEX[2]) begin
      n_fail++; $display("FAIL rstmid_pre: got %h/%h want d/%h", DISP_SEL_OUT, DISP_OUT, HEX[2]);
    end
    RESET = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DISP_SEL_OUT !== 4'hF || DISP_OUT !== 8'hFF || FRAME_TICK !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out: got %h/%h/%b want f/ff/0", DISP_SEL_OUT, DISP_OUT, FRAME_TICK);
    end
    RESET = 1'b0;
    for (int d = 0; d < 4; d++) push_slot(d, seg_exp(4'h0, 1'b0), 16);
    capture_frame(-1, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front(); n_tests++;
      if (obs_sel[s] !== e.sel || obs_out[s] !== e.out || obs_lit[s] != e.lit || obs_shape[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_slot%0d: got sel=%h out=%h lit=%0d shape=%b, want sel=%h out=%h lit=%0d shape=1",
                 s, obs_sel[s], obs_out[s], obs_lit[s], obs_shape[s], e.sel, e.out, e.lit);
      end
    end
    n_tests++;
    if (obs_ticks != 1 || obs_tick_pos != FRAME - 1) begin
      n_fail++; $display("FAIL rstmid_frame_tick: got count=%0d pos=%0d want count=1 pos=71", obs_ticks, obs_tick_pos);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_bright();
    test_mask();
    test_blink();
    test_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

endmodule
